mem_stage: RTL
==============

Name: mem_stage

Overview:
Pipeline stage directly downstream of the execute ALU. It consumes the ALU result (`outData`), the forwarded rt data, the instruction and the control word. For loads and stores it performs a data-memory access through a req/ready handshake, stalling upstream until the access completes. It then presents writeback data, the instruction and the control word to the writeback stage.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ready before aborting the access with mem_err
CTRL_W, `CONTROL_REG_SIZE, width of the control word passed through

Ports:
clock  in  1  single clock; all state changes on rising edge
reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clock
in_valid  in  1  upstream presents a valid instruction this cycle
aluData  in  [0:31]  ALU result; effective address for LW/SW/LB/LBU/SB
rtData  in  [0:31]  store data source
insn  in  [0:31]  instruction; opcode = insn[0:5]
control  in  [0:CTRL_W-1]  control word
stall  out  1  upstream must hold its outputs and must not advance
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  [0:31]  word-aligned address, bits [30:31] = 00
mem_be  out  [0:3]  byte enables; be[0] selects bits [0:7] (big-endian lane 0)
mem_wdata  out  [0:31]  write data
mem_ready  in  1  memory completes the access this cycle; mem_rdata valid on reads
mem_rdata  in  [0:31]  read data
out_valid  out  1  writeback outputs valid this cycle
wbData  out  [0:31]  result to writeback
insn_out  out  [0:31]  registered instruction
control_out  out  [0:CTRL_W-1]  registered control word
mem_err  out  1  one-cycle pulse with out_valid: misaligned access or timeout

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; stall, mem_req, mem_we, out_valid, mem_err = 0; mem_addr, mem_be, mem_wdata, wbData, insn_out = 0; control_out = 0.
  - Reset wins over every other event, including mid-access: mem_req drops at that edge and no out_valid is produced.
- Opcode decode:
  - LW = 100011, LB = 100000, LBU = 100100, SW = 101011, SB = 101000.
  - All other opcodes are non-memory.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, in_valid=1, non-memory instruction:
  - Next edge: out_valid=1, wbData=aluData, insn_out=insn, control_out=control.
  - Latency 1; stall stays 0; back-to-back instructions are accepted every cycle.
- IDLE, in_valid=0: next edge out_valid=0; other outputs hold.
- IDLE, in_valid=1, memory instruction:
  - Misaligned case (LW/SW with aluData[30:31] != 00): no request is issued. Next edge: out_valid=1, mem_err=1, wbData=0, insn_out and control_out latched. Remain in IDLE.
  - Otherwise, next edge:
    - Latch insn, control and the lane offset aluData[30:31].
    - Drive mem_req=1 and mem_addr={aluData[0:29],00}.
    - mem_we=1 for SW/SB, else 0.
    - stall=1; enter ACCESS.
- Byte enables and write data:
  - Word ops: mem_be=1111. SW: mem_wdata=rtData.
  - Byte ops: mem_be one-hot at the lane offset.
  - SB: mem_wdata = rtData[24:31] replicated into all four lanes.
- ACCESS:
  - mem_req, mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready is sampled 1.
  - A wait counter increments each cycle in ACCESS.
  - On an edge where mem_ready=1, mem_req drops to 0 and the FSM enters DONE. wbData is set from the read data:
    - LW: mem_rdata.
    - LB: selected lane sign-extended from lane bit 0.
    - LBU: selected lane zero-extended.
    - SW/SB: wbData=aluData.
  - Timeout: if the counter reaches TIMEOUT without mem_ready, mem_req drops and the FSM enters DONE with the error flag set and wbData=0.
  - mem_ready arriving on the same edge the counter hits TIMEOUT counts as success.
- DONE (one cycle):
  - out_valid=1; mem_err=error flag; stall=0 at the next edge; return to IDLE.
  - The upstream instruction held during the stall is accepted in the IDLE cycle that follows.
- mem_ready is ignored outside ACCESS.
- in_valid is ignored while stall=1.
- out_valid is high for exactly one cycle per accepted instruction.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> all outputs 0. Release with ADDU insn, aluData=0x00000005 -> next cycle out_valid=1, wbData=0x00000005, stall=0.
- LW at aluData=0x00000100, mem_ready after 3 ACCESS cycles, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, mem_we=0 held for 3 cycles; wbData=0xDEADBEEF with a single out_valid pulse; stall high throughout.
- SB at aluData=0x00000102, rtData=0x123456AB, immediate ready -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1, mem_addr=0x100.
- LB/LBU at offset 3 with mem_rdata=0x000000F0 -> LB wbData=0xFFFFFFF0; LBU wbData=0x000000F0.
- Misaligned LW at aluData=0x00000101 -> mem_req never asserted; out_valid=1 with mem_err=1 one cycle later. Separately, no mem_ready for TIMEOUT cycles -> mem_err pulse and wbData=0.
- reset_n=0 during ACCESS -> mem_req=0 and stall=0 after that edge; no out_valid. A following ADDU completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory access pipeline stage: load/store via req/ready handshake, stalls upstream until done
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CTRL_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [0:31]       aluData,
    input  logic [0:31]       rtData,
    input  logic [0:31]       insn,
    input  logic [0:CTRL_W-1] control,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [0:31]       mem_addr,
    output logic [0:3]        mem_be,
    output logic [0:31]       mem_wdata,
    input  logic              mem_ready,
    input  logic [0:31]       mem_rdata,
    output logic              out_valid,
    output logic [0:31]       wbData,
    output logic [0:31]       insn_out,
    output logic [0:CTRL_W-1] control_out,
    output logic              mem_err
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state_q, state_d;
    logic stall_q, stall_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic out_valid_q, out_valid_d, mem_err_q, mem_err_d, err_q, err_d;
    logic [0:31] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [0:31] wb_q, wb_d, insn_out_q, insn_out_d;
    logic [0:3] mem_be_q, mem_be_d;
    logic [0:CTRL_W-1] control_out_q, control_out_d;
    logic [1:0] off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] in_op, held_op;
    logic [1:0] in_off;
    logic in_mem, in_store, in_word, in_misalign, timed_out;
    logic [0:3] byte_be;
    logic [0:7] lane;
    logic [0:31] load_data;

    assign in_op       = insn[0:5];
    assign in_off      = aluData[30:31];
    assign in_store    = (in_op == OP_SW) || (in_op == OP_SB);
    assign in_word     = (in_op == OP_LW) || (in_op == OP_SW);
    assign in_mem      = in_word || in_store || (in_op == OP_LB) || (in_op == OP_LBU);
    assign in_misalign = in_word && (in_off != 2'b00);
    assign held_op     = insn_out_q[0:5];
    assign timed_out   = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        byte_be = 4'b0000;
        byte_be[in_off] = 1'b1;
    end

    // Lane 0 is the most significant byte; the address low bits pick the lane.
    always_comb begin
        case (off_q)
            2'd0:    lane = mem_rdata[0:7];
            2'd1:    lane = mem_rdata[8:15];
            2'd2:    lane = mem_rdata[16:23];
            default: lane = mem_rdata[24:31];
        endcase
        case (held_op)
            OP_LW:   load_data = mem_rdata;
            OP_LB:   load_data = {{24{lane[0]}}, lane};
            OP_LBU:  load_data = {24'h000000, lane};
            default: load_data = {mem_addr_q[0:29], off_q};
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            stall_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            mem_err_q     <= 1'b0;
            err_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_q          <= '0;
            insn_out_q    <= '0;
            control_out_q <= '0;
            off_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            out_valid_q   <= out_valid_d;
            mem_err_q     <= mem_err_d;
            err_q         <= err_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_q          <= wb_d;
            insn_out_q    <= insn_out_d;
            control_out_q <= control_out_d;
            off_q         <= off_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_mem && !in_misalign) state_d = ACCESS;
            ACCESS:  if (mem_ready || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_d       = stall_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        out_valid_d   = 1'b0;
        mem_err_d     = 1'b0;
        err_d         = err_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_d          = wb_q;
        insn_out_d    = insn_out_q;
        control_out_d = control_out_q;
        off_d         = off_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    insn_out_d    = insn;
                    control_out_d = control;
                    if (!in_mem) begin
                        out_valid_d = 1'b1;
                        wb_d        = aluData;
                    end else if (in_misalign) begin
                        out_valid_d = 1'b1;
                        mem_err_d   = 1'b1;
                        wb_d        = '0;
                    end else begin
                        off_d       = in_off;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {aluData[0:29], 2'b00};
                        mem_we_d    = in_store;
                        mem_be_d    = in_word ? 4'b1111 : byte_be;
                        mem_wdata_d = in_word ? rtData : {4{rtData[24:31]}};
                        stall_d     = 1'b1;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    wb_d      = load_data;
                end else if (timed_out) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    wb_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                mem_err_d   = err_q;
                stall_d     = 1'b0;
            end
            default: ;
        endcase
    end

    assign stall       = stall_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign out_valid   = out_valid_q;
    assign mem_err     = mem_err_q;
    assign wbData      = wb_q;
    assign insn_out    = insn_out_q;
    assign control_out = control_out_q;
endmodule
